// File: rtl/img_readout_chunker_pkg.sv
// Shared image-readout types: chunk geometry constants and the read-side FSM state type.
package img_readout_chunker_pkg;

  // One chunk is one SD write unit (512 B of 16-bit words).
  localparam int unsigned ImgReadoutChunk_Words = 256;
  localparam int unsigned ImgReadoutChunk_Depth = 2;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StStream
  } rd_state_e;

endpackage

// File: rtl/img_readout_chunker_ram.sv
// Simple dual-port word store: one write port, one registered read port (iCE40 BRAM shape).
module img_readout_chunker_ram #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 512,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/img_readout_chunker.sv
// Buffers the image readout stream and releases it to the consumer only in whole chunks.
module img_readout_chunker
  import img_readout_chunker_pkg::*;
#(
  parameter int unsigned ChunkWords  = ImgReadoutChunk_Words,
  parameter int unsigned DepthChunks = ImgReadoutChunk_Depth
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        in_rst,
  input  logic        in_ready,
  output logic        in_trigger,
  input  logic [15:0] in_data,
  output logic        out_chunkReady,
  output logic        out_ready,
  input  logic        out_trigger,
  output logic [15:0] out_data,
  output logic        out_chunkDone,
  output logic [15:0] status_chunkCount
);

  localparam int unsigned Cap  = ChunkWords * DepthChunks;
  localparam int unsigned AW   = $clog2(Cap);
  localparam int unsigned PtrW = AW + 1;
  localparam int unsigned CW   = $clog2(ChunkWords);
  localparam int unsigned KW   = $clog2(DepthChunks) + 1;
  localparam logic [PtrW-1:0] CapP    = PtrW'(Cap);
  localparam logic [CW-1:0]   LastOff = '1;

  // Async assert, release synchronised through two flops.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) rst_sync_q <= 2'b00;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, occ;
  logic [KW-1:0]   committed_q;
  logic [15:0]     status_q;
  logic            done_q;
  rd_state_e       state_q, state_d;
  logic            in_xfer, out_xfer, commit, start, last;
  logic            re;
  logic [AW-1:0]   raddr;
  logic [15:0]     rdata;

  assign occ        = wr_ptr_q - rd_ptr_q;
  assign in_trigger = rst_n_int && !in_rst && (occ < CapP);
  assign in_xfer    = in_ready && in_trigger;
  assign out_ready  = (state_q == StStream);
  assign out_xfer   = out_ready && out_trigger;
  assign commit     = in_xfer && (wr_ptr_q[CW-1:0] == LastOff);
  assign start      = out_xfer && (rd_ptr_q[CW-1:0] == '0);
  assign last       = out_xfer && (rd_ptr_q[CW-1:0] == LastOff);

  assign out_chunkReady    = (committed_q != '0);
  assign out_data          = out_ready ? rdata : 16'h0000;
  assign out_chunkDone     = done_q;
  assign status_chunkCount = status_q;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      committed_q <= '0;
      status_q    <= '0;
      done_q      <= 1'b0;
    end else if (in_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      committed_q <= '0;
      status_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      if (in_xfer)  wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (out_xfer) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (commit && !start)      committed_q <= committed_q + KW'(1);
      else if (start && !commit) committed_q <= committed_q - KW'(1);
      done_q <= last;
      if (last && status_q != 16'hFFFF) status_q <= status_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int)  state_q <= StIdle;
    else if (in_rst) state_q <= StIdle;
    else             state_q <= state_d;
  end

  // committed_q counts chunks not yet started, so at a chunk's end it says whether another waits.
  always_comb begin
    state_d = state_q;
    re      = 1'b0;
    raddr   = rd_ptr_q[AW-1:0];
    unique case (state_q)
      StIdle: begin
        if (committed_q != '0) state_d = StFetch;
      end
      StFetch: begin
        re      = 1'b1;
        state_d = StStream;
      end
      StStream: begin
        if (last) begin
          state_d = (committed_q != '0) ? StFetch : StIdle;
        end else if (out_xfer) begin
          re    = 1'b1;
          raddr = rd_ptr_q[AW-1:0] + AW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  img_readout_chunker_ram #(
    .Width(16),
    .Depth(Cap)
  ) u_ram (
    .clk  (clk),
    .we   (in_xfer),
    .waddr(wr_ptr_q[AW-1:0]),
    .wdata(in_data),
    .re   (re),
    .raddr(raddr),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_img_readout_chunker.sv
// Directed bench for img_readout_chunker: fill-level vector table plus hand-written corner sequences.
module tb_img_readout_chunker;

  localparam int CW = 256;

  logic        clk = 1'b0;
  logic        rst_;
  logic        in_rst;
  logic        in_ready;
  logic        in_trigger;
  logic [15:0] in_data;
  logic        out_chunkReady;
  logic        out_ready;
  logic        out_trigger;
  logic [15:0] out_data;
  logic        out_chunkDone;
  logic [15:0] status_chunkCount;

  always #5 clk = ~clk;

  img_readout_chunker dut (
    .clk              (clk),
    .rst_             (rst_),
    .in_rst           (in_rst),
    .in_ready         (in_ready),
    .in_trigger       (in_trigger),
    .in_data          (in_data),
    .out_chunkReady   (out_chunkReady),
    .out_ready        (out_ready),
    .out_trigger      (out_trigger),
    .out_data         (out_data),
    .out_chunkDone    (out_chunkDone),
    .status_chunkCount(status_chunkCount)
  );

  int passed = 0;
  int total  = 0;
  int done_pulses = 0;
  logic [15:0] q_commit[$];
  logic [15:0] q_part[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: words become readable only once a full chunk has been accepted.
  always @(negedge clk) begin
    if (!rst_ || in_rst) begin
      q_commit.delete();
      q_part.delete();
    end else begin
      if (out_ready && out_trigger) begin
        if (q_commit.size() == 0) check("out_without_commit", {31'b0, out_ready}, 32'd0);
        else check("out_data", {16'b0, out_data}, {16'b0, q_commit.pop_front()});
      end
      if (in_ready && in_trigger) begin
        q_part.push_back(in_data);
        if (q_part.size() == CW) begin
          foreach (q_part[i]) q_commit.push_back(q_part[i]);
          q_part.delete();
        end
      end
    end
    if (out_chunkDone) done_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic produce(input int n, input logic [15:0] first, input bit dec, input bit rnd);
    logic [15:0] v;
    int got;
    int cyc;
    v = first;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 40000) begin
      in_data  = v;
      in_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (in_ready && in_trigger) begin
        got++;
        v = dec ? v - 16'd1 : v + 16'd1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_ready = 1'b0;
    if (got < n) check("produce_timeout", got, n);
  endtask

  task automatic consume(input int n, input bit rnd);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 40000) begin
      out_trigger = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_ready && out_trigger) got++;
      @(posedge clk);
      #1;
      cyc++;
    end
    out_trigger = 1'b0;
    if (got < n) check("consume_timeout", got, n);
  endtask

  task automatic flush();
    in_rst = 1'b1;
    tick(1);
    in_rst = 1'b0;
  endtask

  typedef struct {
    int          nwords;
    logic [15:0] base;
    logic        exp_chunk_ready;
    logic        exp_in_trig;
    logic        exp_out_ready;
    logic [15:0] exp_data;
    int          exp_chunks;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int bad;
    int d0;
    int w;

    vecs[0] = '{nwords: 255, base: 16'h1000, exp_chunk_ready: 1'b0, exp_in_trig: 1'b1,
                exp_out_ready: 1'b0, exp_data: 16'h0000, exp_chunks: 0};
    vecs[1] = '{nwords: 256, base: 16'h1100, exp_chunk_ready: 1'b1, exp_in_trig: 1'b1,
                exp_out_ready: 1'b1, exp_data: 16'h1100, exp_chunks: 1};
    vecs[2] = '{nwords: 300, base: 16'h1200, exp_chunk_ready: 1'b1, exp_in_trig: 1'b1,
                exp_out_ready: 1'b1, exp_data: 16'h1200, exp_chunks: 1};
    vecs[3] = '{nwords: 511, base: 16'h1400, exp_chunk_ready: 1'b1, exp_in_trig: 1'b1,
                exp_out_ready: 1'b1, exp_data: 16'h1400, exp_chunks: 1};
    vecs[4] = '{nwords: 512, base: 16'h1800, exp_chunk_ready: 1'b1, exp_in_trig: 1'b0,
                exp_out_ready: 1'b1, exp_data: 16'h1800, exp_chunks: 2};

    // Reset state with upstream and consumer both active.
    rst_ = 1'b0;
    in_rst = 1'b0;
    in_ready = 1'b1;
    in_data = 16'hBEEF;
    out_trigger = 1'b1;
    #12;
    check("rst_in_trigger", {31'b0, in_trigger}, 32'd0);
    check("rst_out_ready", {31'b0, out_ready}, 32'd0);
    check("rst_chunk_ready", {31'b0, out_chunkReady}, 32'd0);
    check("rst_chunk_done", {31'b0, out_chunkDone}, 32'd0);
    check("rst_out_data", {16'b0, out_data}, 32'd0);
    check("rst_status", {16'b0, status_chunkCount}, 32'd0);
    in_ready = 1'b0;
    out_trigger = 1'b0;
    @(posedge clk);
    #2;
    rst_ = 1'b1;
    tick(1);
    @(negedge clk);
    check("rel_edge1_in_trigger", {31'b0, in_trigger}, 32'd0);
    tick(1);
    @(negedge clk);
    check("rel_edge2_in_trigger", {31'b0, in_trigger}, 32'd1);
    tick(1);

    // Fill-level table: write N words, inspect flags, drain whole chunks, flush.
    foreach (vecs[k]) begin
      produce(vecs[k].nwords, vecs[k].base, 1'b0, 1'b0);
      in_ready = !vecs[k].exp_in_trig;
      in_data = 16'hDEAD;
      tick(3);
      in_ready = 1'b0;
      @(negedge clk);
      check("tbl_chunk_ready", {31'b0, out_chunkReady}, {31'b0, vecs[k].exp_chunk_ready});
      check("tbl_in_trigger", {31'b0, in_trigger}, {31'b0, vecs[k].exp_in_trig});
      check("tbl_out_ready", {31'b0, out_ready}, {31'b0, vecs[k].exp_out_ready});
      check("tbl_out_data", {16'b0, out_data}, {16'b0, vecs[k].exp_data});
      tick(1);
      consume(vecs[k].exp_chunks * CW, 1'b0);
      tick(2);
      @(negedge clk);
      check("tbl_status", {16'b0, status_chunkCount}, vecs[k].exp_chunks);
      check("tbl_drained_out_ready", {31'b0, out_ready}, 32'd0);
      tick(1);
      flush();
      @(negedge clk);
      check("tbl_flush_status", {16'b0, status_chunkCount}, 32'd0);
      check("tbl_flush_in_trigger", {31'b0, in_trigger}, 32'd1);
      tick(1);
    end

    // A partial chunk must never become visible.
    produce(255, 16'h5000, 1'b0, 1'b0);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (out_chunkReady || out_ready) bad++;
    end
    tick(1);
    check("partial_quiet", bad, 32'd0);
    flush();

    // Commit-to-output latency on the 256th word.
    produce(255, 16'h0000, 1'b0, 1'b0);
    in_ready = 1'b1;
    in_data = 16'h00FF;
    @(negedge clk);
    check("lat_pre_commit_ready", {31'b0, out_chunkReady}, 32'd0);
    tick(1);
    in_ready = 1'b0;
    @(negedge clk);
    check("lat_commit_ready", {31'b0, out_chunkReady}, 32'd1);
    check("lat_out_ready_c1", {31'b0, out_ready}, 32'd0);
    tick(1);
    @(negedge clk);
    check("lat_out_ready_c2", {31'b0, out_ready}, 32'd0);
    tick(1);
    @(negedge clk);
    check("lat_out_ready_c3", {31'b0, out_ready}, 32'd1);
    check("lat_first_word", {16'b0, out_data}, 32'd0);
    tick(1);
    d0 = done_pulses;
    consume(CW, 1'b0);
    tick(2);
    check("lat_done_pulses", done_pulses - d0, 32'd1);
    check("lat_status", {16'b0, status_chunkCount}, 32'd1);

    // Mid-chunk flush, then a fresh chunk reads from its first word.
    produce(300, 16'h2000, 1'b0, 1'b0);
    consume(100, 1'b0);
    @(negedge clk);
    check("flush_pre_out_ready", {31'b0, out_ready}, 32'd1);
    tick(1);
    flush();
    @(negedge clk);
    check("flush_out_ready", {31'b0, out_ready}, 32'd0);
    check("flush_chunk_ready", {31'b0, out_chunkReady}, 32'd0);
    check("flush_status", {16'b0, status_chunkCount}, 32'd0);
    tick(1);
    produce(CW, 16'h3000, 1'b0, 1'b0);
    w = 0;
    while (!out_ready && w < 20) begin
      tick(1);
      w++;
    end
    check("fresh_first_word", {16'b0, out_data}, 32'h3000);
    consume(CW, 1'b0);
    tick(2);
    check("fresh_status", {16'b0, status_chunkCount}, 32'd1);
    flush();

    // Random handshakes over 16 chunks of a decrementing pattern.
    d0 = done_pulses;
    fork
      produce(4096, 16'h0FFF, 1'b1, 1'b1);
      consume(4096, 1'b1);
    join
    tick(3);
    check("rand_done_pulses", done_pulses - d0, 32'd16);
    check("rand_status", {16'b0, status_chunkCount}, 32'd16);
    check("rand_model_empty", q_commit.size() + q_part.size(), 32'd0);

    // Asynchronous reset mid-stream.
    produce(CW, 16'h7000, 1'b0, 1'b0);
    consume(50, 1'b0);
    #2;
    rst_ = 1'b0;
    #1;
    check("arst_in_trigger", {31'b0, in_trigger}, 32'd0);
    check("arst_out_ready", {31'b0, out_ready}, 32'd0);
    check("arst_chunk_ready", {31'b0, out_chunkReady}, 32'd0);
    check("arst_chunk_done", {31'b0, out_chunkDone}, 32'd0);
    check("arst_out_data", {16'b0, out_data}, 32'd0);
    check("arst_status", {16'b0, status_chunkCount}, 32'd0);
    @(posedge clk);
    #2;
    rst_ = 1'b1;
    tick(1);
    @(negedge clk);
    check("arst_edge1_in_trigger", {31'b0, in_trigger}, 32'd0);
    tick(1);
    @(negedge clk);
    check("arst_edge2_in_trigger", {31'b0, in_trigger}, 32'd1);
    tick(1);
    produce(CW, 16'h7100, 1'b0, 1'b0);
    consume(CW, 1'b0);
    tick(2);
    check("arst_after_status", {16'b0, status_chunkCount}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
